data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
Responder end of the MEM-stage data-memory interface. It accepts the chip-enable/write-enable/byte-select/address/data request that the MEM stage drives and performs the access on an internal word-organised, byte-lane-writable RAM. It returns read data with a one-cycle ack and holds the pipeline through a stall output while the access is in flight. The number of wait states is configurable, so the core can be exercised against slow memory before the real bus bridge exists.

Parameters:
ADDR_W, 10, word-address width; RAM depth = 2**ADDR_W 32-bit words
LATENCY, 0, extra wait cycles inserted before the access completes; legal range 0..15
INIT_FILE, "", optional hex image loaded at elaboration; empty means contents are undefined

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low (0 = reset)
ce_i  in  1  request valid; held stable by upstream while stall_o=1
we_i  in  1  1 = write, 0 = read
addr_i  in  32  byte address; bits [ADDR_W+1:2] select the word, all other bits are ignored
sel_i  in  4  byte-lane enables; sel_i[3] maps to data[31:24] (byte offset 0), sel_i[0] maps to data[7:0] (byte offset 3)
data_i  in  32  write data, lane-replicated by upstream
data_o  out  32  read data, full word, valid while ack_o=1
ack_o  out  1  one-cycle completion pulse
stall_o  out  1  combinational: ce_i & ~ack_o

Behaviour:
- Reset (rst=0 at a clk edge): state<=IDLE, cnt<=0, ack_o<=0, data_o<=0, captured request cleared. RAM contents are not altered. Reset wins over every other event, including mid-access; an in-flight write that has not reached its access edge is dropped.
- States: IDLE, BUSY, RESP.
- IDLE: if ce_i=1, capture we_i, word address, sel_i and data_i; set cnt<=LATENCY; go to BUSY. Otherwise stay in IDLE.
- BUSY: if cnt!=0, decrement cnt and stay. If cnt==0, perform the access on this edge:
  - Write: update only the lanes enabled in sel_i from the captured data.
  - Read: data_o <= RAM[word].
  - Then ack_o<=1 and go to RESP.
- RESP: ack_o=1 for exactly this cycle. At the next edge: ack_o<=0, state<=IDLE. ce_i sampled during RESP belongs to the completed request and is ignored.
- Timing: a request asserted in cycle 0 is acked in cycle LATENCY+2. A back-to-back request appears in cycle LATENCY+3 and is accepted there.
- On a write, data_o returns the pre-write word (read-before-write) with ack_o=1. Upstream ignores this value.
- sel_i=4'b0000 with we_i=1: no RAM change, still acked in normal timing.
- Address wrap: word index = addr_i[ADDR_W+1:2]; higher bits alias.
- Byte offset addr_i[1:0] is not decoded; lane selection is carried entirely by sel_i.
- The responder does not check misalignment.
- Changing the request while stall_o=1 is a protocol violation. The captured copy is used; the behaviour is defined but the bench flags it.

Decomposition:
- Shared package: the state encoding (IDLE/BUSY/RESP), the LANE constants mapping sel bit to data slice, and MAX_LATENCY=15.
- One sub-module, be_word_ram: a synchronous single-port 32-bit RAM with 4 byte-write enables and a registered read, instantiated at depth 2**ADDR_W.
- The FSM and counter stay in the top module.

Test Plan:
- LATENCY=0, write ce=1 we=1 addr=0x10 sel=1111 data=0xDEADBEEF, then read addr=0x10 -> ack_o in cycle 2 of each request; the read returns data_o=0xDEADBEEF; stall_o high in cycles 0-1.
- Byte write addr=0x11 sel=0100 data=0x55555555 over word 0xDEADBEEF, then read -> 0xDE55BEEF. Halfword sel=0011 data=0x12341234 -> 0xDE551234.
- LATENCY=3, read request at cycle 0 -> stall_o=1 in cycles 0-4, ack_o=1 only in cycle 5, stall_o=0 in cycle 5.
- Write with sel=0000 data=0xFFFFFFFF, then read -> word unchanged; the write is still acked at cycle LATENCY+2.
- LATENCY=5, write issued, rst=0 pulsed in cycle 3 -> ack_o=0, data_o=0 and state IDLE after that edge; a subsequent read shows the old word (write dropped).
- Wrap/back-to-back: ADDR_W=10, write 0xA5A5A5A5 to addr=0x1000, then immediately read addr=0x0000 -> 0xA5A5A5A5; the second request is accepted the cycle after RESP with no lost cycle.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the MEM-stage data-memory responder.
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int unsigned MAX_LATENCY = 15;
  localparam int unsigned CNT_W       = 4;
  localparam int unsigned NUM_LANES   = 4;
  localparam int unsigned LANE_W      = 8;

  // sel[n] owns data[8n+7:8n]; lane 3 is byte offset 0 (big-endian lane order)
  function automatic int unsigned lane_lsb(input int unsigned lane);
    return lane * LANE_W;
  endfunction

endpackage

// File: rtl/data_mem_responder_be_word_ram.sv
// Single-port 32-bit word RAM with per-byte write enables and a registered,
// read-before-write output that can be synchronously cleared.
module be_word_ram
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter string       INIT_FILE = ""
) (
  input  logic                 clk_i,
  input  logic                 rd_clr_i,
  input  logic                 en_i,
  input  logic [NUM_LANES-1:0] be_i,
  input  logic [ADDR_W-1:0]    addr_i,
  input  logic [31:0]          wdata_i,
  output logic [31:0]          rdata_o
);

  logic [31:0] mem_q [2**ADDR_W];
  logic [31:0] rdata_q;

  // Preloading an image is left to the memory compiler / simulation wrapper.
  if (INIT_FILE != "") begin : g_init_external
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (en_i && be_i[i]) begin
        mem_q[addr_i][lane_lsb(i) +: LANE_W] <= wdata_i[lane_lsb(i) +: LANE_W];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rd_clr_i) begin
      rdata_q <= '0;
    end else if (en_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data-memory responder: captures a request, waits LATENCY cycles,
// performs the access on the byte-writable RAM and returns a one-cycle ack.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned LATENCY   = 0,
  parameter string       INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        stall_o
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ack_q, ack_d;
  logic                req_we_q, req_we_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic [3:0]          req_sel_q, req_sel_d;
  logic [31:0]         req_data_q, req_data_d;

  logic                ram_en;
  logic [3:0]          ram_be;

  logic unused_addr;
  assign unused_addr = ^{addr_i[31:ADDR_W+2], addr_i[1:0]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      ack_q      <= 1'b0;
      req_we_q   <= 1'b0;
      req_addr_q <= '0;
      req_sel_q  <= '0;
      req_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
      req_we_q   <= req_we_d;
      req_addr_q <= req_addr_d;
      req_sel_q  <= req_sel_d;
      req_data_q <= req_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ack_d      = 1'b0;
    req_we_d   = req_we_q;
    req_addr_d = req_addr_q;
    req_sel_d  = req_sel_q;
    req_data_d = req_data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (ce_i) begin
          req_we_d   = we_i;
          req_addr_d = addr_i[ADDR_W+1:2];
          req_sel_d  = sel_i;
          req_data_d = data_i;
          cnt_d      = CNT_INIT;
          state_d    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          ack_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Access is gated by rst so a reset landing on the access edge drops the write.
  always_comb begin
    ram_en = rst && (state_q == ST_BUSY) && (cnt_q == '0);
    ram_be = {4{ram_en & req_we_q}} & req_sel_q;
  end

  be_word_ram #(
    .ADDR_W    (ADDR_W),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk_i    (clk),
    .rd_clr_i (!rst),
    .en_i     (ram_en),
    .be_i     (ram_be),
    .addr_i   (req_addr_q),
    .wdata_i  (req_data_q),
    .rdata_o  (data_o)
  );

  assign ack_o   = ack_q;
  assign stall_o = ce_i & ~ack_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder at LATENCY 0, 3 and 5.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] wdata;
  logic        ce_l0, ce_l3, ce_l5;
  logic [31:0] do_l0, do_l3, do_l5;
  logic        ack_l0, ack_l3, ack_l5;
  logic        st_l0, st_l3, st_l5;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [31:0] rd;

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_W(10), .LATENCY(0)) u_l0 (
    .clk(clk), .rst(rst), .ce_i(ce_l0), .we_i(we), .addr_i(addr), .sel_i(sel),
    .data_i(wdata), .data_o(do_l0), .ack_o(ack_l0), .stall_o(st_l0));

  data_mem_responder #(.ADDR_W(10), .LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .ce_i(ce_l3), .we_i(we), .addr_i(addr), .sel_i(sel),
    .data_i(wdata), .data_o(do_l3), .ack_o(ack_l3), .stall_o(st_l3));

  data_mem_responder #(.ADDR_W(10), .LATENCY(5)) u_l5 (
    .clk(clk), .rst(rst), .ce_i(ce_l5), .we_i(we), .addr_i(addr), .sel_i(sel),
    .data_i(wdata), .data_o(do_l5), .ack_o(ack_l5), .stall_o(st_l5));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_ce(input int unsigned lat, input logic v);
    case (lat)
      0: ce_l0 = v;
      3: ce_l3 = v;
      default: ce_l5 = v;
    endcase
  endtask

  task automatic peek(input int unsigned lat, output logic a, output logic s, output logic [31:0] d);
    case (lat)
      0: begin a = ack_l0; s = st_l0; d = do_l0; end
      3: begin a = ack_l3; s = st_l3; d = do_l3; end
      default: begin a = ack_l5; s = st_l5; d = do_l5; end
    endcase
  endtask

  // Called just after a rising edge; returns just after the edge that ends RESP,
  // so an immediately following call is the back-to-back case.
  task automatic run_req(input string tag, input int unsigned lat, input logic w,
                         input logic [31:0] a_in, input logic [3:0] s_in,
                         input logic [31:0] d_in, output logic [31:0] rdata);
    logic        a, s;
    logic [31:0] d;
    rdata = '0;
    we = w; addr = a_in; sel = s_in; wdata = d_in;
    set_ce(lat, 1'b1);
    for (int unsigned c = 0; c <= lat + 2; c++) begin
      @(negedge clk);
      peek(lat, a, s, d);
      check($sformatf("%s ack c%0d", tag, c), {31'd0, a}, {31'd0, (c == lat + 2)});
      check($sformatf("%s stall c%0d", tag, c), {31'd0, s}, {31'd0, (c < lat + 2)});
      if (c == lat + 2) rdata = d;
      @(posedge clk); #1;
    end
    set_ce(lat, 1'b0);
  endtask

  initial begin
    rst = 1'b0; we = 1'b0; addr = '0; sel = '0; wdata = '0;
    ce_l0 = 1'b0; ce_l3 = 1'b0; ce_l5 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst ack_l0", {31'd0, ack_l0}, 32'd0);
    check("rst data_l0", do_l0, 32'h0);
    check("rst ack_l5", {31'd0, ack_l5}, 32'd0);
    check("rst data_l5", do_l5, 32'h0);
    check("rst stall_l3", {31'd0, st_l3}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // LATENCY 0: full write then back-to-back read
    run_req("l0 wr full", 0, 1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, rd);
    run_req("l0 rd full", 0, 1'b0, 32'h10, 4'b1111, 32'h0, rd);
    check("l0 rd full data", rd, 32'hDEADBEEF);

    run_req("l0 wr byte", 0, 1'b1, 32'h11, 4'b0100, 32'h55555555, rd);
    check("l0 wr byte rbw", rd, 32'hDEADBEEF);
    run_req("l0 rd byte", 0, 1'b0, 32'h10, 4'b1111, 32'h0, rd);
    check("l0 rd byte data", rd, 32'hDE55BEEF);

    run_req("l0 wr half", 0, 1'b1, 32'h12, 4'b0011, 32'h12341234, rd);
    check("l0 wr half rbw", rd, 32'hDE55BEEF);
    run_req("l0 rd half", 0, 1'b0, 32'h10, 4'b1111, 32'h0, rd);
    check("l0 rd half data", rd, 32'hDE551234);

    // Address wrap: 0x1000 aliases word 0
    run_req("l0 wr wrap", 0, 1'b1, 32'h1000, 4'b1111, 32'hA5A5A5A5, rd);
    run_req("l0 rd wrap", 0, 1'b0, 32'h0000, 4'b1111, 32'h0, rd);
    check("l0 rd wrap data", rd, 32'hA5A5A5A5);
    @(negedge clk);
    check("l0 ack drops", {31'd0, ack_l0}, 32'd0);
    @(posedge clk); #1;

    // LATENCY 3
    run_req("l3 wr", 3, 1'b1, 32'h40, 4'b1111, 32'hCAFEF00D, rd);
    run_req("l3 rd", 3, 1'b0, 32'h40, 4'b1111, 32'h0, rd);
    check("l3 rd data", rd, 32'hCAFEF00D);
    run_req("l3 wr sel0", 3, 1'b1, 32'h40, 4'b0000, 32'hFFFFFFFF, rd);
    check("l3 wr sel0 rbw", rd, 32'hCAFEF00D);
    run_req("l3 rd sel0", 3, 1'b0, 32'h40, 4'b1111, 32'h0, rd);
    check("l3 rd sel0 data", rd, 32'hCAFEF00D);

    // LATENCY 5: reset mid-access drops the write
    run_req("l5 wr", 5, 1'b1, 32'h20, 4'b1111, 32'h11223344, rd);
    run_req("l5 rd", 5, 1'b0, 32'h20, 4'b1111, 32'h0, rd);
    check("l5 rd data", rd, 32'h11223344);
    we = 1'b1; addr = 32'h20; sel = 4'b1111; wdata = 32'h99999999;
    ce_l5 = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("l5 busy stall", {31'd0, st_l5}, 32'd1);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    ce_l5 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("l5 post-rst ack", {31'd0, ack_l5}, 32'd0);
    check("l5 post-rst data", do_l5, 32'h0);
    @(posedge clk); #1;
    run_req("l5 rd after rst", 5, 1'b0, 32'h20, 4'b1111, 32'h0, rd);
    check("l5 rd after rst data", rd, 32'h11223344);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
